bus_slave_mux: RTL and testbench



---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_wdt.sv | 34 +++
 rtl/bus_slave_mux.sv | 215 +++++++++++++++++++++
 tb/tb_bus_slave_mux.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the system-bus slave fan-out and its watchdog.
package bus_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STRB = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } bus_state_e;

  // Read data returned whenever a transaction ends in an error response.
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Width of the saturating timeout counter.
  localparam int TMO_CNT_W = 16;

  // Ceiling log2, usable in parameter expressions; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_wdt.sv
// Transaction watchdog: a down-counter reloaded by clear and decremented while
// enabled. expire is raised in the cycle in which the counter sits at zero,
// which is TIMEOUT enabled cycles after the last clear.
module bus_wdt
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = clog2(TIMEOUT);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Reload on clear, otherwise count down towards zero while enabled.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/bus_slave_mux.sv
// Single-clock bus fan-out: routes one master request to one of NS slave
// ports selected by an address field, supervises each transaction with a
// watchdog and guarantees exactly one acknowledge per accepted request.
//
// state | meaning
// IDLE  | waiting for a request; decodes the slave index
// STRB  | one-cycle read/write strobe to the selected slave
// WAIT  | waiting for the selected slave's ack or the watchdog
// RESP  | one-cycle acknowledge to the master with latched data/err
module bus_slave_mux
  import bus_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NS = 8,
  parameter int DEC_LSB = 20,
  parameter int TIMEOUT = 256,
  parameter logic [DW-1:0] ERR_RDATA = DW'(ERR_RDATA_DEFAULT)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [AW-1:0]        sys_addr_i,
  input  logic [DW-1:0]        sys_wdata_i,
  input  logic [DW/8-1:0]      sys_sel_i,
  input  logic                 sys_wen_i,
  input  logic                 sys_ren_i,
  output logic [DW-1:0]        sys_rdata_o,
  output logic                 sys_err_o,
  output logic                 sys_ack_o,
  output logic [AW-1:0]        slv_addr_o,
  output logic [DW-1:0]        slv_wdata_o,
  output logic [DW/8-1:0]      slv_sel_o,
  output logic [NS-1:0]        slv_wen_o,
  output logic [NS-1:0]        slv_ren_o,
  input  logic [NS*DW-1:0]     slv_rdata_i,
  input  logic [NS-1:0]        slv_err_i,
  input  logic [NS-1:0]        slv_ack_i,
  output logic                 busy_o,
  output logic [TMO_CNT_W-1:0] tmo_cnt_o
);

  localparam int SW = DW / 8;
  localparam int IW = (clog2(NS) < 1) ? 1 : clog2(NS);

  bus_state_e state_q, state_d;

  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q;
  logic [SW-1:0]        sel_q;
  logic [IW-1:0]        idx_q;
  logic                 wr_q;
  logic [DW-1:0]        rdata_q;
  logic                 err_q;
  logic [TMO_CNT_W-1:0] tmo_q;

  logic [IW-1:0] req_idx;
  logic          req_valid;
  logic          req_decoded;

  logic          ack_sel;
  logic          err_sel;
  logic [DW-1:0] rdata_sel;

  logic          capture;
  logic          load_resp;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          tmo_hit;

  logic          wdt_clear;
  logic          wdt_enable;
  logic          wdt_expire;

  assign req_idx     = sys_addr_i[DEC_LSB +: IW];
  assign req_valid   = sys_wen_i | sys_ren_i;
  // The extra leading zero keeps the compare meaningful when NS == 2**IW.
  assign req_decoded = ({1'b0, req_idx} < (IW + 1)'(NS));

  // Pick the ack, error and read data of the slave addressed by the latched index.
  always_comb begin
    ack_sel   = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NS; k++) begin
      if (idx_q == IW'(k)) begin
        ack_sel   = slv_ack_i[k];
        err_sel   = slv_err_i[k];
        rdata_sel = slv_rdata_i[k*DW +: DW];
      end
    end
  end

  bus_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear  (wdt_clear),
    .enable (wdt_enable),
    .expire (wdt_expire)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control; a slave ack in the expiry cycle wins.
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    load_resp  = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    tmo_hit    = 1'b0;
    wdt_clear  = 1'b0;
    wdt_enable = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wdt_clear = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          if (req_decoded) begin
            state_d = ST_STRB;
          end else begin
            state_d    = ST_RESP;
            load_resp  = 1'b1;
            resp_rdata = ERR_RDATA;
            resp_err   = 1'b1;
          end
        end
      end
      ST_STRB, ST_WAIT: begin
        wdt_enable = 1'b1;
        if (ack_sel) begin
          state_d    = ST_RESP;
          load_resp  = 1'b1;
          resp_rdata = wr_q ? '0 : rdata_sel;
          resp_err   = err_sel;
        end else if (wdt_expire) begin
          state_d    = ST_RESP;
          load_resp  = 1'b1;
          resp_rdata = ERR_RDATA;
          resp_err   = 1'b1;
          tmo_hit    = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture, response latch and saturating timeout count.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      if (capture) begin
        addr_q  <= sys_addr_i;
        wdata_q <= sys_wdata_i;
        sel_q   <= sys_sel_i;
        idx_q   <= req_idx;
        wr_q    <= sys_wen_i;
      end
      if (load_resp) begin
        rdata_q <= resp_rdata;
        err_q   <= resp_err;
      end
      if (tmo_hit && (tmo_q != '1)) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  // One-hot strobe towards the addressed slave during the STRB cycle only.
  always_comb begin
    slv_wen_o = '0;
    slv_ren_o = '0;
    if (state_q == ST_STRB) begin
      for (int k = 0; k < NS; k++) begin
        if (idx_q == IW'(k)) begin
          slv_wen_o[k] = wr_q;
          slv_ren_o[k] = !wr_q;
        end
      end
    end
  end

  assign slv_addr_o  = addr_q;
  assign slv_wdata_o = wdata_q;
  assign slv_sel_o   = sel_q;
  assign sys_rdata_o = rdata_q;
  assign sys_err_o   = err_q;
  assign sys_ack_o   = (state_q == ST_RESP);
  assign busy_o      = (state_q != ST_IDLE);
  assign tmo_cnt_o   = tmo_q;

endmodule

// File: tb/tb_bus_slave_mux.sv
// Randomized bench for bus_slave_mux: slave behaviour is scripted per
// transaction, expected timing/data come from the latency rules, and a
// compare process checks every output on every cycle.
module tb_bus_slave_mux;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NS = 5;
  localparam int IW = 3;
  localparam int DEC_LSB = 20;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic              clk;
  logic              rstn_i;
  logic [AW-1:0]     sys_addr_i;
  logic [DW-1:0]     sys_wdata_i;
  logic [SW-1:0]     sys_sel_i;
  logic              sys_wen_i;
  logic              sys_ren_i;
  logic [DW-1:0]     sys_rdata_o;
  logic              sys_err_o;
  logic              sys_ack_o;
  logic [AW-1:0]     slv_addr_o;
  logic [DW-1:0]     slv_wdata_o;
  logic [SW-1:0]     slv_sel_o;
  logic [NS-1:0]     slv_wen_o;
  logic [NS-1:0]     slv_ren_o;
  logic [NS*DW-1:0]  slv_rdata_i;
  logic [NS-1:0]     slv_err_i;
  logic [NS-1:0]     slv_ack_i;
  logic              busy_o;
  logic [15:0]       tmo_cnt_o;

  bus_slave_mux #(
    .AW(AW), .DW(DW), .NS(NS), .DEC_LSB(DEC_LSB), .TIMEOUT(TIMEOUT), .ERR_RDATA(ERRV)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .sys_addr_i(sys_addr_i), .sys_wdata_i(sys_wdata_i), .sys_sel_i(sys_sel_i),
    .sys_wen_i(sys_wen_i), .sys_ren_i(sys_ren_i),
    .sys_rdata_o(sys_rdata_o), .sys_err_o(sys_err_o), .sys_ack_o(sys_ack_o),
    .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o), .slv_sel_o(slv_sel_o),
    .slv_wen_o(slv_wen_o), .slv_ren_o(slv_ren_o),
    .slv_rdata_i(slv_rdata_i), .slv_err_i(slv_err_i), .slv_ack_i(slv_ack_i),
    .busy_o(busy_o), .tmo_cnt_o(tmo_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // Model of the transaction in flight (or the last one completed).
  bit          chk_en = 1'b0;
  bit          txn_active = 1'b0;
  bit          t_wr;
  int          t_k;
  int          t_strobe;
  int          t_ack;
  int          t_busy_from;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_sel;
  logic [31:0] t_rdata;
  bit          t_err;
  bit          t_tmo;
  logic [31:0] prev_rdata = '0;
  bit          prev_err = 1'b0;
  int          tmo_base = 0;

  // Observations of the current transaction, used by directed literal checks.
  int          obs_ack_cyc;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [NS-1:0] obs_wen_or;
  logic [NS-1:0] obs_ren_or;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  bit            done_now;
  logic [NS-1:0] exp_wen;
  logic [NS-1:0] exp_ren;
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      done_now = txn_active && (cyc >= t_ack);
      exp_wen = '0;
      exp_ren = '0;
      if (txn_active && cyc == t_strobe) begin
        if (t_wr) exp_wen[t_k] = 1'b1;
        else exp_ren[t_k] = 1'b1;
        check("slv_addr", slv_addr_o, t_addr);
        check("slv_wdata", slv_wdata_o, t_wdata);
        check("slv_sel", slv_sel_o, t_sel);
      end
      check("sys_ack", sys_ack_o, txn_active && (cyc == t_ack));
      check("busy", busy_o, txn_active && (cyc >= t_busy_from) && (cyc <= t_ack));
      check("slv_wen", slv_wen_o, exp_wen);
      check("slv_ren", slv_ren_o, exp_ren);
      check("sys_rdata", sys_rdata_o, done_now ? t_rdata : prev_rdata);
      check("sys_err", sys_err_o, done_now ? t_err : prev_err);
      check("tmo_cnt", tmo_cnt_o, tmo_base + ((done_now && t_tmo) ? 1 : 0));
      if (sys_ack_o) begin
        obs_ack_cyc = cyc;
        obs_rdata = sys_rdata_o;
        obs_err = sys_err_o;
      end
      obs_wen_or = obs_wen_or | slv_wen_o;
      obs_ren_or = obs_ren_or | slv_ren_o;
    end
  end

  // Random slave activity; kmask hides the target slave except when it acks.
  task automatic drive_slaves(input logic [NS-1:0] kmask, input bit ack_k, input int k,
                              input logic [31:0] sdata, input bit serr);
    logic [NS-1:0] noise;
    noise = NS'($urandom) & NS'($urandom);
    slv_ack_i = (noise & ~kmask) | (ack_k ? kmask : '0);
    for (int s = 0; s < NS; s++) slv_rdata_i[s*DW +: DW] = $urandom;
    slv_err_i = NS'($urandom);
    if (ack_k && k < NS) begin
      slv_rdata_i[k*DW +: DW] = sdata;
      slv_err_i[k] = serr;
    end
  endtask

  // One master transaction starting at the current negedge. n<0: slave never acks.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] sel, input int n,
                         input logic [31:0] sdata, input bit serr, input int busy_req_at,
                         input int rst_at, input int late_at, output int t0);
    int k, ackoff, last, b_at, r_at;
    bit dec_err;
    logic [NS-1:0] kmask;
    k = int'(addr[DEC_LSB +: IW]);
    dec_err = (k >= NS);
    t0 = cyc;
    if (txn_active) begin
      prev_rdata = t_rdata;
      prev_err = t_err;
      if (t_tmo) tmo_base++;
    end
    txn_active = 1'b1;
    t_wr = wr;
    t_k = k;
    t_addr = addr;
    t_wdata = wd;
    t_sel = sel;
    t_busy_from = t0 + 1;
    if (dec_err) begin
      t_strobe = -1; ackoff = 1; t_rdata = ERRV; t_err = 1'b1; t_tmo = 1'b0;
    end else if (n >= 0 && n <= TIMEOUT - 1) begin
      t_strobe = t0 + 1; ackoff = n + 2; t_rdata = wr ? 32'h0 : sdata; t_err = serr; t_tmo = 1'b0;
    end else begin
      t_strobe = t0 + 1; ackoff = TIMEOUT + 1; t_rdata = ERRV; t_err = 1'b1; t_tmo = 1'b1;
    end
    t_ack = t0 + ackoff;
    obs_ack_cyc = -1;
    obs_wen_or = '0;
    obs_ren_or = '0;
    b_at = (busy_req_at > ackoff) ? ackoff : busy_req_at;
    r_at = (rst_at > ackoff) ? ackoff : rst_at;
    kmask = dec_err ? '0 : NS'(1 << k);
    sys_addr_i = addr;
    sys_wdata_i = wd;
    sys_sel_i = sel;
    sys_wen_i = wr;
    sys_ren_i = rd;
    drive_slaves('0, 1'b0, 0, 32'h0, 1'b0);
    last = ackoff + 1;
    if (n >= 0 && n + 2 > last) last = n + 2;
    if (late_at >= 0 && late_at + 1 > last) last = late_at + 1;
    for (int off = 1; off <= last; off++) begin
      @(negedge clk);
      sys_wen_i = 1'b0;
      sys_ren_i = 1'b0;
      sys_addr_i = $urandom;
      sys_wdata_i = $urandom;
      sys_sel_i = SW'($urandom);
      if (b_at > 0 && off == b_at) begin
        {sys_wen_i, sys_ren_i} = 2'($urandom_range(1, 3));
      end
      drive_slaves(kmask, (!dec_err && n >= 0 && off == n + 1) || (off == late_at), k, sdata, serr);
      if (r_at > 0 && off == r_at + 1) begin
        txn_active = 1'b0;
        prev_rdata = '0;
        prev_err = 1'b0;
        tmo_base = 0;
        check("rst_ack", sys_ack_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_strobes", {slv_wen_o, slv_ren_o}, 0);
        check("rst_rdata_err", {sys_rdata_o, sys_err_o}, 0);
        check("rst_slv_bus", {slv_addr_o, slv_wdata_o, slv_sel_o}, 0);
        check("rst_tmo", tmo_cnt_o, 0);
        rstn_i = 1'b1;
        break;
      end
      if (r_at > 0 && off == r_at) rstn_i = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  int t0;
  initial begin
    logic [31:0] a;
    int k, n, mode, bq, rq, la, op;
    rstn_i = 1'b0;
    sys_addr_i = '0; sys_wdata_i = '0; sys_sel_i = '0;
    sys_wen_i = 1'b0; sys_ren_i = 1'b0;
    slv_rdata_i = '0; slv_err_i = '0; slv_ack_i = '0;
    repeat (3) @(negedge clk);
    check("reset_ack_busy", {sys_ack_o, busy_o}, 0);
    check("reset_strobes", {slv_wen_o, slv_ren_o}, 0);
    check("reset_rdata_err", {sys_rdata_o, sys_err_o}, 0);
    check("reset_tmo", tmo_cnt_o, 0);
    rstn_i = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Write to slave 3, immediate ack.
    run_txn(1, 0, 32'h0030_0010, 32'h1234_5678, 4'hF, 0, 32'h0, 0, -1, -1, -1, t0);
    check("w3_latency", obs_ack_cyc - t0, 2);
    check("w3_wen", obs_wen_or, 5'b01000);
    check("w3_ren", obs_ren_or, 5'b00000);
    check("w3_err", obs_err, 0);

    // Read from slave 0 with n=5.
    run_txn(0, 1, 32'h0000_0004, 32'h0, 4'hF, 5, 32'hCAFE_0001, 0, -1, -1, -1, t0);
    check("r0_latency", obs_ack_cyc - t0, 7);
    check("r0_rdata", obs_rdata, 32'hCAFE_0001);
    check("r0_ren", obs_ren_or, 5'b00001);

    // Hung slave 2 with a late ack, then a normal request.
    run_txn(0, 1, 32'h0020_0000, 32'h0, 4'hF, -1, 32'h0, 0, -1, -1, 20, t0);
    check("hung_latency", obs_ack_cyc - t0, 17);
    check("hung_err_rdata", {obs_err, obs_rdata}, {1'b1, 32'hDEAD_BEEF});
    check("hung_tmo", tmo_cnt_o, 1);
    run_txn(1, 0, 32'h0010_0008, 32'hA5A5_0001, 4'h3, 2, 32'h0, 0, -1, -1, -1, t0);
    check("after_hung_latency", obs_ack_cyc - t0, 4);
    check("after_hung_wen", obs_wen_or, 5'b00010);

    // Undecoded index 6.
    run_txn(0, 1, 32'h0060_0000, 32'h0, 4'hF, 0, 32'h0, 0, -1, -1, -1, t0);
    check("undec_latency", obs_ack_cyc - t0, 1);
    check("undec_err", obs_err, 1);
    check("undec_strobes", {obs_wen_or, obs_ren_or}, 0);

    // Ack exactly at watchdog expiry.
    run_txn(0, 1, 32'h0040_0000, 32'h0, 4'hF, 15, 32'h5A5A_0004, 0, -1, -1, -1, t0);
    check("expiry_latency", obs_ack_cyc - t0, 17);
    check("expiry_err_rdata", {obs_err, obs_rdata}, {1'b0, 32'h5A5A_0004});
    check("expiry_tmo", tmo_cnt_o, 1);

    // Both request bits set is a write.
    run_txn(1, 1, 32'h0010_0000, 32'h0BAD_F00D, 4'h1, 1, 32'h1111_2222, 1, -1, -1, -1, t0);
    check("both_wen", obs_wen_or, 5'b00010);
    check("both_rdata_err", {obs_err, obs_rdata}, {1'b1, 32'h0});

    // Request while busy is ignored.
    run_txn(0, 1, 32'h0020_0000, 32'h0, 4'hF, 3, 32'h7777_0002, 0, 2, -1, -1, t0);
    check("busy_ign_latency", obs_ack_cyc - t0, 5);
    check("busy_ign_strobes", {obs_wen_or, obs_ren_or}, {5'b00000, 5'b00100});

    // Reset during WAIT.
    run_txn(0, 1, 32'h0010_0000, 32'h0, 4'hF, -1, 32'h0, 0, -1, 4, -1, t0);
    check("rst_no_ack", obs_ack_cyc, -1);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 7);
      a = $urandom;
      a[DEC_LSB +: IW] = 3'(k);
      op = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        6: n = 14;
        7: n = 15;
        8: n = 16;
        9: n = -1;
        default: n = $urandom_range(0, 6);
      endcase
      mode = $urandom_range(0, 9);
      bq = (mode == 0) ? $urandom_range(1, 8) : -1;
      rq = (mode == 1) ? $urandom_range(1, 8) : -1;
      la = (n < 0 && mode == 2) ? $urandom_range(TIMEOUT + 2, TIMEOUT + 4) : -1;
      run_txn(op != 1, op != 0, a, $urandom, 4'($urandom), n, $urandom, 1'($urandom),
              bq, rq, la, t0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
